// File: rtl/stack_engine.sv
// Byte-wide hardware stack pointer engine driving an external stack RAM.
// Accepts one op at a time in IDLE and sequences 8/16-bit pushes and pops with limit checking.
module stack_engine #(
    parameter int              AW       = 8,
    parameter logic [AW-1:0]   RST_SP   = 'h07,
    parameter logic [AW-1:0]   LIMIT_LO = 'h07,
    parameter logic [AW-1:0]   LIMIT_HI = 'h7F,
    parameter bit              GROW_UP  = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [2:0]    i_op,
    input  logic [15:0]   i_wdata,
    input  logic [7:0]    i_mem_rdata,
    output logic [AW-1:0] o_sp,
    output logic [AW-1:0] o_mem_addr,
    output logic [7:0]    o_mem_wdata,
    output logic          o_mem_we,
    output logic          o_mem_re,
    output logic [15:0]   o_pop_data,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic          o_ovf,
    output logic          o_unf
);

    localparam logic [2:0] OP_WR     = 3'b001;
    localparam logic [2:0] OP_PUSH8  = 3'b010;
    localparam logic [2:0] OP_POP8   = 3'b011;
    localparam logic [2:0] OP_PUSH16 = 3'b100;
    localparam logic [2:0] OP_POP16  = 3'b101;
    localparam logic [2:0] OP_CLR    = 3'b110;

    typedef enum logic [2:0] {
        IDLE,
        PUSH_A,
        PUSH_B,
        POP_A,
        POP_B,
        CAP,
        ERR,
        ONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] sp_q, sp_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          is16_q, is16_d;
    logic [7:0]    pop_hi_q, pop_hi_d;
    logic [15:0]   pop_data_q, pop_data_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic          op_is16;
    logic          in_range;
    logic [AW-1:0] need;
    logic [AW-1:0] room_hi;
    logic [AW-1:0] room_lo;
    logic          push_ok;
    logic          pop_ok;
    logic [AW-1:0] sp_push;
    logic [AW-1:0] sp_pop;
    logic          mem_we;
    logic          mem_re;
    logic [7:0]    mem_wdata;
    logic          done;
    logic          err;

    // Room check: the distances to both limits are only meaningful while the pointer is in range.
    always_comb begin
        op_is16  = (i_op == OP_PUSH16) || (i_op == OP_POP16);
        need     = op_is16 ? AW'(2) : AW'(1);
        in_range = (sp_q >= LIMIT_LO) && (sp_q <= LIMIT_HI);
        room_hi  = LIMIT_HI - sp_q;
        room_lo  = sp_q - LIMIT_LO;
        push_ok  = in_range && (GROW_UP ? (room_hi >= need) : (room_lo >= need));
        pop_ok   = in_range && (GROW_UP ? (room_lo >= need) : (room_hi >= need));
        sp_push  = GROW_UP ? (sp_q + AW'(1)) : (sp_q - AW'(1));
        sp_pop   = GROW_UP ? (sp_q - AW'(1)) : (sp_q + AW'(1));
    end

    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        wdata_d    = wdata_q;
        is16_d     = is16_q;
        pop_hi_d   = pop_hi_q;
        pop_data_d = pop_data_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_wdata  = 8'h00;
        done       = 1'b0;
        err        = 1'b0;

        case (state_q)
            IDLE: begin
                is16_d = op_is16;
                case (i_op)
                    OP_WR: begin
                        sp_d    = i_wdata[AW-1:0];
                        state_d = ONE;
                    end
                    OP_CLR: begin
                        ovf_d   = 1'b0;
                        unf_d   = 1'b0;
                        state_d = ONE;
                    end
                    OP_PUSH8, OP_PUSH16: begin
                        wdata_d = i_wdata;
                        if (push_ok) begin
                            sp_d    = sp_push;
                            state_d = PUSH_A;
                        end else begin
                            ovf_d   = 1'b1;
                            state_d = ERR;
                        end
                    end
                    OP_POP8, OP_POP16: begin
                        if (pop_ok) begin
                            state_d = POP_A;
                        end else begin
                            unf_d   = 1'b1;
                            state_d = ERR;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
            PUSH_A: begin
                mem_we    = 1'b1;
                mem_wdata = wdata_q[7:0];
                if (is16_q) begin
                    sp_d    = sp_push;
                    state_d = PUSH_B;
                end else begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            PUSH_B: begin
                mem_we    = 1'b1;
                mem_wdata = wdata_q[15:8];
                done      = 1'b1;
                state_d   = IDLE;
            end
            POP_A: begin
                mem_re  = 1'b1;
                sp_d    = sp_pop;
                state_d = is16_q ? POP_B : CAP;
            end
            POP_B: begin
                pop_hi_d = i_mem_rdata;
                mem_re   = 1'b1;
                sp_d     = sp_pop;
                state_d  = CAP;
            end
            CAP: begin
                pop_data_d = is16_q ? {pop_hi_q, i_mem_rdata} : {8'h00, i_mem_rdata};
                done       = 1'b1;
                state_d    = IDLE;
            end
            ERR: begin
                done    = 1'b1;
                err     = 1'b1;
                state_d = IDLE;
            end
            ONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset suppresses strobes in the same cycle so an aborted op never touches memory again.
        if (i_rst) begin
            mem_we = 1'b0;
            mem_re = 1'b0;
            done   = 1'b0;
            err    = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            sp_q       <= RST_SP;
            wdata_q    <= 16'h0000;
            is16_q     <= 1'b0;
            pop_hi_q   <= 8'h00;
            pop_data_q <= 16'h0000;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            wdata_q    <= wdata_d;
            is16_q     <= is16_d;
            pop_hi_q   <= pop_hi_d;
            pop_data_q <= pop_data_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    always_comb begin
        o_sp        = sp_q;
        o_mem_we    = mem_we;
        o_mem_re    = mem_re;
        o_mem_addr  = (mem_we || mem_re) ? sp_q : '0;
        o_mem_wdata = mem_we ? mem_wdata : 8'h00;
        o_pop_data  = pop_data_q;
        o_busy      = (state_q != IDLE) && !i_rst;
        o_done      = done;
        o_err       = err;
        o_ovf       = ovf_q;
        o_unf       = unf_q;
    end

endmodule

// File: tb/tb_stack_engine.sv
// Bench for stack_engine: directed scenarios with literal expectations, then random ops
// checked every cycle against a transaction-level queue model with its own byte memory.
module tb_stack_engine;

    localparam logic [2:0] NOP    = 3'b000;
    localparam logic [2:0] WR     = 3'b001;
    localparam logic [2:0] PUSH8  = 3'b010;
    localparam logic [2:0] POP8   = 3'b011;
    localparam logic [2:0] PUSH16 = 3'b100;
    localparam logic [2:0] POP16  = 3'b101;
    localparam logic [2:0] CLR    = 3'b110;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [2:0]  i_op = NOP;
    logic [15:0] i_wdata = 16'h0000;
    logic [7:0]  i_mem_rdata;
    logic [7:0]  o_sp, o_mem_addr, o_mem_wdata;
    logic        o_mem_we, o_mem_re, o_busy, o_done, o_err, o_ovf, o_unf;
    logic [15:0] o_pop_data;

    int n_checks = 0;
    int n_fail = 0;
    int we_count = 0;
    int re_count = 0;
    int done_count = 0;

    stack_engine dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_op(i_op), .i_wdata(i_wdata),
        .i_mem_rdata(i_mem_rdata), .o_sp(o_sp), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we), .o_mem_re(o_mem_re),
        .o_pop_data(o_pop_data), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_ovf(o_ovf), .o_unf(o_unf)
    );

    always #5 i_clk = ~i_clk;

    // Stack RAM with one-cycle read latency; idle read data is garbage to expose timing slips.
    logic [7:0] ram [0:255];
    initial for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    always @(posedge i_clk) begin
        if (o_mem_we) ram[o_mem_addr] <= o_mem_wdata;
        i_mem_rdata <= o_mem_re ? ram[o_mem_addr] : 8'($urandom);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] data, input logic rst);
        i_op = op;
        i_wdata = data;
        i_rst = rst;
        @(posedge i_clk);
        #1;
        i_op = NOP;
        i_rst = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic err);
        lat = 1;
        while (!o_done && lat < 16) begin
            applyStimulus(NOP, 16'h0, 1'b0);
            lat++;
        end
        err = o_err;
        checkOutput("done_seen", {31'd0, o_done}, 32'd1);
    endtask

    typedef struct {
        bit        we, re, done, err, set_pop;
        bit [7:0]  addr, wdata, sp_after;
        bit [15:0] pop_val;
    } cyc_t;

    cyc_t      q[$];
    bit [7:0]  m_mem [0:255];
    bit [7:0]  m_sp;
    bit        m_ovf, m_unf;
    bit [15:0] m_pop;
    bit        started = 1'b0;

    initial for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;

    function automatic cyc_t blank(input bit [7:0] sp);
        cyc_t c;
        c = '{we: 0, re: 0, done: 0, err: 0, set_pop: 0, addr: 0, wdata: 0, sp_after: sp, pop_val: 0};
        return c;
    endfunction

    // Expand one accepted op into the per-cycle bus activity it must produce.
    task automatic model_accept(input logic [2:0] op, input logic [15:0] data);
        cyc_t c, c2, c3;
        int   s, n;
        bit   ok;
        s = int'(m_sp);
        n = (op == PUSH16 || op == POP16) ? 2 : 1;
        case (op)
            WR: begin
                m_sp = data[7:0];
                c = blank(m_sp); c.done = 1; q.push_back(c);
            end
            CLR: begin
                m_ovf = 0; m_unf = 0;
                c = blank(m_sp); c.done = 1; q.push_back(c);
            end
            PUSH8, PUSH16: begin
                ok = (s >= 7) && (s <= 127) && (127 - s >= n);
                if (!ok) begin
                    m_ovf = 1;
                    c = blank(m_sp); c.done = 1; c.err = 1; q.push_back(c);
                end else begin
                    m_sp = 8'(s + 1);
                    c = blank(8'(s + n)); c.we = 1; c.addr = 8'(s + 1); c.wdata = data[7:0];
                    c.done = (n == 1);
                    q.push_back(c);
                    if (n == 2) begin
                        c2 = blank(8'(s + 2)); c2.we = 1; c2.addr = 8'(s + 2); c2.wdata = data[15:8];
                        c2.done = 1;
                        q.push_back(c2);
                    end
                end
            end
            POP8, POP16: begin
                ok = (s >= 7) && (s <= 127) && (s - 7 >= n);
                if (!ok) begin
                    m_unf = 1;
                    c = blank(m_sp); c.done = 1; c.err = 1; q.push_back(c);
                end else begin
                    c = blank(8'(s - 1)); c.re = 1; c.addr = 8'(s); q.push_back(c);
                    if (n == 2) begin
                        c2 = blank(8'(s - 2)); c2.re = 1; c2.addr = 8'(s - 1); q.push_back(c2);
                        c3 = blank(8'(s - 2)); c3.done = 1; c3.set_pop = 1;
                        c3.pop_val = {m_mem[8'(s)], m_mem[8'(s - 1)]};
                        q.push_back(c3);
                    end else begin
                        c3 = blank(8'(s - 1)); c3.done = 1; c3.set_pop = 1;
                        c3.pop_val = {8'h00, m_mem[8'(s)]};
                        q.push_back(c3);
                    end
                end
            end
            default: ;
        endcase
    endtask

    always @(posedge i_clk) begin
        cyc_t r;
        if (i_rst) begin
            q.delete();
            m_sp = 8'h07; m_ovf = 0; m_unf = 0; m_pop = 16'h0;
            started = 1'b1;
        end else if (started) begin
            if (q.size() > 0) begin
                r = q.pop_front();
                if (r.we) m_mem[r.addr] = r.wdata;
                if (r.set_pop) m_pop = r.pop_val;
                m_sp = r.sp_after;
            end else begin
                model_accept(i_op, i_wdata);
            end
        end
    end

    always @(negedge i_clk) begin
        cyc_t e;
        bit   act;
        if (started) begin
            e = blank(m_sp);
            if (q.size() > 0) e = q[0];
            act = !i_rst;
            checkOutput("sp", {24'd0, o_sp}, {24'd0, m_sp});
            checkOutput("busy", {31'd0, o_busy}, {31'd0, q.size() > 0 && act});
            checkOutput("done", {31'd0, o_done}, {31'd0, e.done && act});
            if (e.done && act) checkOutput("err", {31'd0, o_err}, {31'd0, e.err});
            checkOutput("mem_we", {31'd0, o_mem_we}, {31'd0, e.we && act});
            checkOutput("mem_re", {31'd0, o_mem_re}, {31'd0, e.re && act});
            checkOutput("mem_addr", {24'd0, o_mem_addr}, {24'd0, ((e.we || e.re) && act) ? e.addr : 8'h00});
            checkOutput("mem_wdata", {24'd0, o_mem_wdata}, {24'd0, (e.we && act) ? e.wdata : 8'h00});
            checkOutput("ovf", {31'd0, o_ovf}, {31'd0, m_ovf});
            checkOutput("unf", {31'd0, o_unf}, {31'd0, m_unf});
            checkOutput("pop_data", {16'd0, o_pop_data}, {16'd0, m_pop});
        end
        if (o_mem_we) we_count++;
        if (o_mem_re) re_count++;
        if (o_done) done_count++;
    end

    initial begin
        int   lat;
        logic err;
        int   we0, re0, done0;
        logic [2:0]  op;
        logic [15:0] data;
        logic        rst;

        applyStimulus(NOP, 16'h0, 1'b1);
        applyStimulus(NOP, 16'h0, 1'b1);
        checkOutput("rst_sp", {24'd0, o_sp}, 32'h07);
        checkOutput("rst_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("rst_ovf", {31'd0, o_ovf}, 32'd0);
        checkOutput("rst_unf", {31'd0, o_unf}, 32'd0);

        applyStimulus(PUSH16, 16'h1234, 1'b0);
        wait_done(lat, err);
        checkOutput("push16_lat", lat, 32'd2);
        checkOutput("push16_err", {31'd0, err}, 32'd0);
        applyStimulus(NOP, 16'h0, 1'b0);
        checkOutput("push16_lo", {24'd0, ram[8'h08]}, 32'h34);
        checkOutput("push16_hi", {24'd0, ram[8'h09]}, 32'h12);
        checkOutput("push16_sp", {24'd0, o_sp}, 32'h09);

        applyStimulus(POP16, 16'h0, 1'b0);
        wait_done(lat, err);
        checkOutput("pop16_lat", lat, 32'd3);
        applyStimulus(NOP, 16'h0, 1'b0);
        checkOutput("pop16_data", {16'd0, o_pop_data}, 32'h1234);
        checkOutput("pop16_sp", {24'd0, o_sp}, 32'h07);

        re0 = re_count;
        applyStimulus(POP8, 16'h0, 1'b0);
        wait_done(lat, err);
        checkOutput("pop8_unf_err", {31'd0, err}, 32'd1);
        applyStimulus(NOP, 16'h0, 1'b0);
        checkOutput("pop8_unf_flag", {31'd0, o_unf}, 32'd1);
        checkOutput("pop8_unf_sp", {24'd0, o_sp}, 32'h07);
        checkOutput("pop8_unf_noread", re_count - re0, 32'd0);
        applyStimulus(CLR, 16'h0, 1'b0);
        applyStimulus(NOP, 16'h0, 1'b0);
        checkOutput("clr_unf", {31'd0, o_unf}, 32'd0);

        applyStimulus(WR, 16'h007E, 1'b0);
        applyStimulus(NOP, 16'h0, 1'b0);
        we0 = we_count;
        applyStimulus(PUSH16, 16'hBEEF, 1'b0);
        wait_done(lat, err);
        applyStimulus(NOP, 16'h0, 1'b0);
        checkOutput("ovf_flag", {31'd0, o_ovf}, 32'd1);
        checkOutput("ovf_sp", {24'd0, o_sp}, 32'h7E);
        checkOutput("ovf_nowrite", we_count - we0, 32'd0);
        applyStimulus(PUSH8, 16'h00AB, 1'b0);
        wait_done(lat, err);
        checkOutput("push8_lat", lat, 32'd1);
        applyStimulus(NOP, 16'h0, 1'b0);
        checkOutput("push8_top", {24'd0, ram[8'h7F]}, 32'hAB);
        checkOutput("push8_sp", {24'd0, o_sp}, 32'h7F);

        applyStimulus(NOP, 16'h0, 1'b1);
        we0 = we_count;
        done0 = done_count;
        applyStimulus(PUSH16, 16'h5678, 1'b0);
        applyStimulus(NOP, 16'h0, 1'b0);
        applyStimulus(NOP, 16'h0, 1'b1);
        applyStimulus(NOP, 16'h0, 1'b0);
        checkOutput("abort_writes", we_count - we0, 32'd1);
        checkOutput("abort_hi_kept", {24'd0, ram[8'h09]}, 32'h12);
        checkOutput("abort_sp", {24'd0, o_sp}, 32'h07);
        checkOutput("abort_nodone", done_count - done0, 32'd0);

        we0 = we_count;
        re0 = re_count;
        applyStimulus(PUSH8, 16'h0011, 1'b0);
        applyStimulus(PUSH8, 16'h0022, 1'b0);
        applyStimulus(NOP, 16'h0, 1'b0);
        checkOutput("busy_ign_writes", we_count - we0, 32'd1);
        checkOutput("busy_ign_reads", re_count - re0, 32'd0);
        checkOutput("busy_ign_data", {24'd0, ram[8'h08]}, 32'h11);
        checkOutput("busy_ign_sp", {24'd0, o_sp}, 32'h08);

        for (int i = 0; i < 4000; i++) begin
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) op = ($urandom_range(0, 1) == 0) ? PUSH8 : PUSH16;
            data = 16'($urandom);
            if (op == WR) begin
                case ($urandom_range(0, 3))
                    0: data = {8'h00, 8'($urandom)};
                    1: data = {8'h00, 8'($urandom_range(8'h7C, 8'h81))};
                    2: data = {8'h00, 8'($urandom_range(8'h05, 8'h0A))};
                    default: data = {8'h00, 8'($urandom_range(8'h07, 8'h7F))};
                endcase
            end
            rst = ($urandom_range(0, 99) == 0);
            applyStimulus(op, data, rst);
        end
        for (int i = 0; i < 8; i++) applyStimulus(NOP, 16'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
